// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: shifts one bit per clock (SRL/SLL/SRA/ROR)
// and presents the registered result with a one-cycle DONE pulse.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             DONE
);

  localparam int LOG2W = $clog2(WIDTH);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] o_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    amount;
  logic [WIDTH-1:0] step_value;
  logic             accept;

  assign accept = START && ((state_q == IDLE) || (state_q == FIN));

  // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH (all bits gone).
  always_comb begin
    amount = '0;
    if (MODE == MODE_ROR) begin
      amount = CW'(B[LOG2W-1:0]);
    end else if (B >= WIDTH'(WIDTH)) begin
      amount = CW'(WIDTH);
    end else begin
      amount = B[CW-1:0];
    end
  end

  always_comb begin
    step_value = work_q;
    case (mode_q)
      MODE_SRL: step_value = {1'b0, work_q[WIDTH-1:1]};
      MODE_SLL: step_value = {work_q[WIDTH-2:0], 1'b0};
      MODE_SRA: step_value = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      MODE_ROR: step_value = {work_q[0], work_q[WIDTH-1:1]};
      default:  step_value = work_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = START ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // START during SHIFT is deliberately ignored: accept only covers IDLE/FIN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work_q <= '0;
      o_q    <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_SRL;
    end else if (accept) begin
      work_q <= A;
      cnt_q  <= amount;
      mode_q <= MODE;
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        work_q <= step_value;
        cnt_q  <= cnt_q - CW'(1);
      end else begin
        o_q <= work_q;
      end
    end
  end

  assign O    = o_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16): latency, results, DONE pulse,
// START-while-busy, back-to-back accept and asynchronous reset behaviour.
module tb_seq_shifter;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [1:0]  MODE;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] O;
  logic        BUSY;
  logic        DONE;

  int checks   = 0;
  int failures = 0;
  logic [15:0] lastO = 16'h0000;

  localparam logic [1:0] SRL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  seq_shifter #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .MODE  (MODE),
    .A     (A),
    .B     (B),
    .O     (O),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one request so that the next rising edge accepts it, then scrambles operands.
  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] a,
                               input logic [15:0] b);
    @(negedge CLK);
    START = 1'b1;
    MODE  = mode;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    MODE  = 2'($urandom);
    A     = 16'($urandom);
    B     = 16'($urandom);
  endtask

  task automatic waitDone(input int budget, output int lat, output int busyCnt,
                          output logic [15:0] holdO);
    lat     = budget;
    busyCnt = 0;
    holdO   = 16'hxxxx;
    for (int j = 0; j < budget; j++) begin
      @(negedge CLK);
      if (j == 0) holdO = O;
      if (DONE) begin
        lat = j;
        break;
      end
      if (BUSY) busyCnt++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] mode, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] expO, input int expLat);
    int lat;
    int busyCnt;
    logic [15:0] holdO;
    applyStimulus(mode, a, b);
    waitDone(40, lat, busyCnt, holdO);
    checkOutput({tag, " lat"}, lat, expLat);
    checkOutput({tag, " O"}, O, expO);
    checkOutput({tag, " busy"}, busyCnt, expLat);
    checkOutput({tag, " hold"}, holdO, lastO);
    @(negedge CLK);
    checkOutput({tag, " pulse"}, DONE, 1'b0);
    lastO = expO;
  endtask

  initial begin
    int lat;
    int busyCnt;
    logic [15:0] holdO;

    RST_N = 1'b0;
    START = 1'b0;
    MODE  = SRL;
    A     = 16'h0000;
    B     = 16'h0000;
    @(negedge CLK);
    checkOutput("reset O", O, 16'h0000);
    checkOutput("reset BUSY", BUSY, 1'b0);
    checkOutput("reset DONE", DONE, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    runOp("srl b1",      SRL, 16'hFFFF, 16'h0001, 16'h7FFF, 2);
    runOp("srl b16",     SRL, 16'hFFFF, 16'h0010, 16'h0000, 17);
    runOp("srl b15",     SRL, 16'hFFFF, 16'h000F, 16'h0001, 16);
    runOp("srl b0",      SRL, 16'hFFFF, 16'h0000, 16'hFFFF, 1);
    runOp("srl b3",      SRL, 16'h8421, 16'h0003, 16'h1084, 4);
    runOp("sra b15",     SRA, 16'h8000, 16'h000F, 16'hFFFF, 16);
    runOp("sra clamp",   SRA, 16'h8000, 16'hFFFF, 16'hFFFF, 17);
    runOp("sra pos",     SRA, 16'h7000, 16'h0003, 16'h0E00, 4);
    runOp("sll b1",      SLL, 16'h0001, 16'h0001, 16'h0002, 2);
    runOp("sll b4",      SLL, 16'h1234, 16'h0004, 16'h2340, 5);
    runOp("sll clamp",   SLL, 16'h0001, 16'h0020, 16'h0000, 17);
    runOp("ror b17",     ROR, 16'h0001, 16'h0011, 16'h8000, 2);
    runOp("ror b16",     ROR, 16'h0001, 16'h0010, 16'h0001, 1);
    runOp("ror b4",      ROR, 16'h1234, 16'h0004, 16'h4123, 5);

    // START pulsed while shifting must neither abort nor queue.
    applyStimulus(SRL, 16'hFFFF, 16'h0004);
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b1;
    MODE  = SLL;
    A     = 16'h0001;
    B     = 16'h0001;
    @(posedge CLK);
    #1;
    START = 1'b0;
    waitDone(40, lat, busyCnt, holdO);
    checkOutput("busy start lat", lat, 3);
    checkOutput("busy start O", O, 16'h0FFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("no queued DONE", DONE, 1'b0);
      checkOutput("no queued BUSY", BUSY, 1'b0);
    end
    lastO = 16'h0FFF;

    // START held high into FIN: second operation starts with no IDLE gap.
    @(negedge CLK);
    START = 1'b1;
    MODE  = SRL;
    A     = 16'h00F0;
    B     = 16'h0004;
    @(posedge CLK);
    #1;
    MODE = SLL;
    A    = 16'h000F;
    B    = 16'h0004;
    waitDone(40, lat, busyCnt, holdO);
    checkOutput("b2b first lat", lat, 5);
    checkOutput("b2b first O", O, 16'h000F);
    checkOutput("b2b first hold", holdO, lastO);
    @(posedge CLK);
    #1;
    START = 1'b0;
    A     = 16'hDEAD;
    waitDone(40, lat, busyCnt, holdO);
    checkOutput("b2b second lat", lat, 5);
    checkOutput("b2b second busy", busyCnt, 5);
    checkOutput("b2b second hold", holdO, 16'h000F);
    checkOutput("b2b second O", O, 16'h00F0);
    lastO = 16'h00F0;

    // Asynchronous reset in the middle of a shift discards it.
    applyStimulus(SRL, 16'hFFFF, 16'h0008);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checkOutput("mid reset O", O, 16'h0000);
    checkOutput("mid reset BUSY", BUSY, 1'b0);
    checkOutput("mid reset DONE", DONE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("reset held DONE", DONE, 1'b0);
    end
    RST_N = 1'b1;
    lastO = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      checkOutput("post reset no DONE", DONE, 1'b0);
    end
    runOp("after reset", SLL, 16'h0003, 16'h0002, 16'h000C, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter: WIDTH, default 16, data/operand width; SHALL be a power of two, >= 4.
REQ-002 Parameter: CW, default log2(WIDTH)+1, internal shift-counter width.
REQ-003 Port: CLK  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Port: START  input  1  request; sampled on the rising edge of CLK.
REQ-006 Port: MODE  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR (rotate right).
REQ-007 Port: A  input  WIDTH  operand to shift.
REQ-008 Port: B  input  WIDTH  unsigned shift amount.
REQ-009 Port: O  output  WIDTH  registered result.
REQ-010 Port: BUSY  output  1  high while an operation is shifting.
REQ-011 Port: DONE  output  1  one-cycle pulse marking a new result on O.

Function
REQ-012 States SHALL be IDLE, SHIFT and FIN; BUSY = (state==SHIFT) and DONE = (state==FIN), both decoded from registered state.
REQ-013 Accept: at a CLK edge where START=1 and state is IDLE or FIN, A, B and MODE SHALL be captured into internal registers, and the state SHALL go to SHIFT.
REQ-014 START while in SHIFT SHALL be ignored; it is neither queued nor an abort.
REQ-015 Effective amount n for SRL/SLL/SRA SHALL be min(B, WIDTH); for ROR it SHALL be B mod WIDTH.
REQ-016 In SHIFT, each edge with counter > 0 SHALL shift the working register by exactly one bit and decrement the counter.
REQ-017 One-bit step per mode:
- SRL: fill MSB with 0.
- SLL: fill LSB with 0.
- SRA: fill MSB with the current MSB.
- ROR: the LSB moves to the MSB.
REQ-018 In SHIFT, the edge with counter == 0 SHALL load O from the working register and move to FIN.
REQ-019 Latency: for an accept at edge k, DONE SHALL be high in the cycle after edge k+n+1; n=0 gives DONE after edge k+1.
REQ-020 In FIN with START=0, the next edge SHALL go to IDLE; with START=1 it SHALL accept back-to-back per REQ-013.
REQ-021 O SHALL change only on entry to FIN and SHALL hold its value in IDLE, SHIFT and FIN until the next FIN entry.
REQ-022 Captured operands SHALL be immune to A/B/MODE changes after the accept edge.
REQ-023 Results SHALL equal the combinational operators: SRL = A>>n, SLL = A<<n, SRA = arithmetic A>>>n (sign fill for n=WIDTH), ROR = rotate right by n.

Reset
REQ-024 RST_N=0 SHALL immediately, without waiting for CLK, force state to IDLE and set O, the working register and the counter to 0, with BUSY=0 and DONE=0.
REQ-025 Reset asserted mid-operation SHALL discard the operation; no DONE SHALL be produced for it.
REQ-026 After RST_N rises, the first START edge SHALL be accepted normally.

Verification (WIDTH=16)
REQ-027 SRL: A=FFFF, B=1, START at edge k -> DONE after edge k+2 with O=7FFF; BUSY high for 2 cycles.
REQ-028 SRL: A=FFFF, B=0010 -> O=0000, DONE after edge k+17; B=000F -> O=0001, DONE after k+16; B=0 -> O=A, DONE after k+1.
REQ-029 SRA: A=8000, B=000F -> O=FFFF; A=8000, B=FFFF (clamped to 16) -> O=FFFF; SLL: A=0001, B=0001 -> O=0002.
REQ-030 ROR: A=0001, B=0011 -> n=1, O=8000, DONE after edge k+2; B=0010 -> O=0001, DONE after k+1.
REQ-031 START pulsed with new operands during SHIFT -> no change to the in-flight result; a START held high into FIN -> second operation accepted with no IDLE cycle.
REQ-032 RST_N low mid-SHIFT -> O=0, BUSY=0 immediately, no DONE; the next START completes correctly.
